// File: rtl/i2c_reg_sequencer_if.sv
// Host request/response and byte-engine command/done bundle for i2c_reg_sequencer.
// slave = sequencer view, master = host + byte-engine view.
interface i2c_reg_sequencer_if;
  logic       req_valid, req_ready, req_rw;
  logic [6:0] req_dev;
  logic [7:0] req_reg, req_wdata;
  logic       rsp_valid, rsp_ready;
  logic [7:0] rsp_rdata;
  logic       rsp_nack, rsp_timeout;
  logic       cmd_valid, cmd_ready;
  logic [2:0] cmd_op;
  logic [7:0] cmd_tx;
  logic       cmd_mack;
  logic       done_valid;
  logic [8:0] done_rx;

  modport slave (
    input  req_valid, req_rw, req_dev, req_reg, req_wdata, rsp_ready,
           cmd_ready, done_valid, done_rx,
    output req_ready, rsp_valid, rsp_rdata, rsp_nack, rsp_timeout,
           cmd_valid, cmd_op, cmd_tx, cmd_mack
  );
  modport master (
    output req_valid, req_rw, req_dev, req_reg, req_wdata, rsp_ready,
           cmd_ready, done_valid, done_rx,
    input  req_ready, rsp_valid, rsp_rdata, rsp_nack, rsp_timeout,
           cmd_valid, cmd_op, cmd_tx, cmd_mack
  );
endinterface

// File: rtl/i2c_reg_sequencer.sv
// Turns single-register I2C read/write requests into byte-engine command sequences.
// Optional command watchdog: define I2C_SEQ_TIMEOUT_EN.
module i2c_reg_sequencer #(
  parameter logic [15:0] CMD_TIMEOUT = 16'hFFFF
) (
  input logic             CLK,
  input logic             RST_N,
  i2c_reg_sequencer_if.slave bus
);
  typedef enum logic [3:0] {
    S_IDLE, S_START, S_DEVW, S_REG, S_WDATA, S_RSTART, S_DEVR, S_RDATA, S_STOP, S_RESP
  } state_t;

  localparam logic [2:0] OP_START = 3'd0, OP_WRITE = 3'd1, OP_READ = 3'd2,
                         OP_STOP  = 3'd3, OP_RESTART = 3'd4;

  state_t     r_state;
  logic       r_wait;
  logic       r_rw;
  logic [6:0] r_dev;
  logic [7:0] r_reg, r_wdata;
  logic       r_cmd_valid, r_cmd_mack, r_rsp_valid, r_rsp_nack;
  logic [2:0] r_cmd_op;
  logic [7:0] r_cmd_tx, r_rsp_rdata;

  state_t     w_next, w_adv;
  logic       w_nack, w_tmo;
  logic [2:0] w_op;
  logic [7:0] w_tx;

`ifdef I2C_SEQ_TIMEOUT_EN
  logic [15:0] r_wdog;
  logic        r_tmo;

  assign w_tmo = r_wait && (r_wdog == CMD_TIMEOUT);

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_wdog <= '0;
      r_tmo  <= 1'b0;
    end else begin
      if (r_cmd_valid && bus.cmd_ready)
        r_wdog <= '0;
      else if (r_wait && r_wdog != 16'hFFFF)
        r_wdog <= r_wdog + 16'd1;
      if (r_state == S_IDLE && bus.req_valid)
        r_tmo <= 1'b0;
      else if (w_tmo && !bus.done_valid)
        r_tmo <= 1'b1;
    end
  end
  assign bus.rsp_timeout = r_tmo;
`else
  assign w_tmo           = 1'b0;
  assign bus.rsp_timeout = 1'b0;
`endif

  // Successor of the current command state once its done arrives; a NACK always routes via STOP.
  always_comb begin
    w_nack = 1'b0;
    w_next = S_STOP;
    case (r_state)
      S_START:  w_next = S_DEVW;
      S_DEVW:   begin w_nack = bus.done_rx[0]; w_next = w_nack ? S_STOP : S_REG; end
      S_REG:    begin
        w_nack = bus.done_rx[0];
        w_next = w_nack ? S_STOP : (r_rw ? S_RSTART : S_WDATA);
      end
      S_WDATA:  begin w_nack = bus.done_rx[0]; w_next = S_STOP; end
      S_RSTART: w_next = S_DEVR;
      S_DEVR:   begin w_nack = bus.done_rx[0]; w_next = w_nack ? S_STOP : S_RDATA; end
      S_RDATA:  w_next = S_STOP;
      S_STOP:   w_next = S_RESP;
      default:  w_next = S_STOP;
    endcase

    if (bus.done_valid)        w_adv = w_next;
    else if (r_state == S_STOP) w_adv = S_RESP;
    else                        w_adv = S_STOP;

    w_op = OP_STOP;
    w_tx = 8'h00;
    case (w_adv)
      S_DEVW:   begin w_op = OP_WRITE; w_tx = {r_dev, 1'b0}; end
      S_REG:    begin w_op = OP_WRITE; w_tx = r_reg; end
      S_WDATA:  begin w_op = OP_WRITE; w_tx = r_wdata; end
      S_RSTART: w_op = OP_RESTART;
      S_DEVR:   begin w_op = OP_WRITE; w_tx = {r_dev, 1'b1}; end
      S_RDATA:  w_op = OP_READ;
      default:  w_op = OP_STOP;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_state     <= S_IDLE;
      r_wait      <= 1'b0;
      r_rw        <= 1'b0;
      r_dev       <= '0;
      r_reg       <= '0;
      r_wdata     <= '0;
      r_cmd_valid <= 1'b0;
      r_cmd_op    <= OP_START;
      r_cmd_tx    <= '0;
      r_cmd_mack  <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_rsp_rdata <= '0;
      r_rsp_nack  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: if (bus.req_valid) begin
          r_rw        <= bus.req_rw;
          r_dev       <= bus.req_dev;
          r_reg       <= bus.req_reg;
          r_wdata     <= bus.req_wdata;
          r_state     <= S_START;
          r_wait      <= 1'b0;
          r_cmd_valid <= 1'b1;
          r_cmd_op    <= OP_START;
          r_cmd_tx    <= '0;
          r_cmd_mack  <= 1'b0;
          r_rsp_rdata <= '0;
          r_rsp_nack  <= 1'b0;
        end
        S_RESP: if (bus.rsp_ready) begin
          r_rsp_valid <= 1'b0;
          r_state     <= S_IDLE;
        end
        default: begin
          if (!r_wait) begin
            if (bus.cmd_ready) begin
              r_cmd_valid <= 1'b0;
              r_wait      <= 1'b1;
            end
          end else if (bus.done_valid || w_tmo) begin
            r_wait  <= 1'b0;
            r_state <= w_adv;
            if (bus.done_valid && w_nack) r_rsp_nack <= 1'b1;
            // Read data survives only a clean completion; a watchdog expiry clears it.
            if (!bus.done_valid)          r_rsp_rdata <= '0;
            else if (r_state == S_RDATA)  r_rsp_rdata <= bus.done_rx[8:1];
            if (w_adv == S_RESP) begin
              r_rsp_valid <= 1'b1;
            end else begin
              r_cmd_valid <= 1'b1;
              r_cmd_op    <= w_op;
              r_cmd_tx    <= w_tx;
              r_cmd_mack  <= (w_adv == S_RDATA);
            end
          end
        end
      endcase
    end
  end

  assign bus.req_ready = (r_state == S_IDLE);
  assign bus.cmd_valid = r_cmd_valid;
  assign bus.cmd_op    = r_cmd_op;
  assign bus.cmd_tx    = r_cmd_tx;
  assign bus.cmd_mack  = r_cmd_mack;
  assign bus.rsp_valid = r_rsp_valid;
  assign bus.rsp_rdata = r_rsp_rdata;
  assign bus.rsp_nack  = r_rsp_nack;
endmodule
